// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one divider among NUM_PORTS requesters, one op in flight.
// Define DIV_SCHED_FLUSH_EN to add flush_i, which abandons the outstanding op.
package div_sched_pkg;
  typedef enum logic [2:0] {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW} fu_op;
endpackage

module div_sched
  import div_sched_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int PTR_BITS      = 1,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
`ifdef DIV_SCHED_FLUSH_EN
  input  logic                     flush_i,
`endif
  input  logic [NUM_PORTS-1:0]     req_valid_i,
  output logic [NUM_PORTS-1:0]     req_ready_o,
  input  fu_op                     req_op_i [NUM_PORTS],
  input  logic [63:0]              req_a_i  [NUM_PORTS],
  input  logic [63:0]              req_b_i  [NUM_PORTS],
  input  logic [TRANS_ID_BITS-1:0] req_id_i [NUM_PORTS],
  output logic                     div_valid_o,
  input  logic                     div_ready_i,
  output fu_op                     div_op_o,
  output logic [63:0]              div_a_o,
  output logic [63:0]              div_b_o,
  output logic [TRANS_ID_BITS-1:0] div_id_o,
  input  logic                     div_done_i,
  input  logic [63:0]              div_result_i,
  input  logic [TRANS_ID_BITS-1:0] div_id_i,
  output logic [NUM_PORTS-1:0]     res_valid_o,
  input  logic [NUM_PORTS-1:0]     res_ready_i,
  output logic [63:0]              res_data_o,
  output logic [TRANS_ID_BITS-1:0] res_id_o,
  output logic                     id_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;
  state_e                   state;
  logic [PTR_BITS-1:0]      ptr, owner, gnt_idx, cand;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic                     gnt_found, grant;
`ifdef DIV_SCHED_FLUSH_EN
  logic                     drop_q;
`endif
  // first valid port at or after ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PTR_BITS'((int'(ptr) + i) % NUM_PORTS);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`ifdef DIV_SCHED_FLUSH_EN
  assign grant = rst_ni && !flush_i && state == IDLE && div_ready_i && gnt_found;
`else
  assign grant = rst_ni && state == IDLE && div_ready_i && gnt_found;
`endif
  assign req_ready_o = grant ? NUM_PORTS'(1) << gnt_idx : '0;
  assign div_valid_o = grant;
  assign div_op_o    = req_op_i[gnt_idx];
  assign div_a_o     = req_a_i[gnt_idx];
  assign div_b_o     = req_b_i[gnt_idx];
  assign div_id_o    = req_id_i[gnt_idx];
  assign res_valid_o = state == HOLD ? NUM_PORTS'(1) << owner : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      id_q <= '0;
      res_data_o <= '0;
      res_id_o <= '0;
      id_err_o <= 1'b0;
`ifdef DIV_SCHED_FLUSH_EN
      drop_q <= 1'b0;
`endif
    end else begin
      id_err_o <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          owner <= gnt_idx;
          id_q <= req_id_i[gnt_idx];
          ptr <= gnt_idx == PTR_BITS'(NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
          state <= BUSY;
        end
        BUSY: begin
`ifdef DIV_SCHED_FLUSH_EN
          if (div_done_i && (drop_q || flush_i)) begin
            drop_q <= 1'b0;
            state <= IDLE;
          end else if (flush_i) drop_q <= 1'b1;
          else
`endif
          if (div_done_i) begin
            res_data_o <= div_result_i;
            res_id_o <= div_id_i;
            id_err_o <= div_id_i != id_q;
            state <= HOLD;
          end
        end
        HOLD: begin
`ifdef DIV_SCHED_FLUSH_EN
          if (flush_i) state <= IDLE;
          else
`endif
          if (res_ready_i[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed and randomized checks of div_sched against a transaction-level model.
module tb_div_sched;
  import div_sched_pkg::*;
  localparam int NP = 2;
  localparam int IDW = 3;
  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
`ifdef DIV_SCHED_FLUSH_EN
  logic           flush_i = 1'b0;
`endif
  logic [NP-1:0]  req_valid_i = '0, req_ready_o, res_valid_o, res_ready_i = '0;
  fu_op           req_op_i [NP];
  logic [63:0]    req_a_i [NP], req_b_i [NP];
  logic [IDW-1:0] req_id_i [NP];
  logic           div_valid_o, id_err_o;
  logic           div_ready_i = 1'b0, div_done_i = 1'b0;
  fu_op           div_op_o;
  logic [63:0]    div_a_o, div_b_o, res_data_o;
  logic [63:0]    div_result_i = '0;
  logic [IDW-1:0] div_id_o, res_id_o;
  logic [IDW-1:0] div_id_i = '0;
  int vectors = 0, miscompares = 0, mptr = 0;

  div_sched #(.NUM_PORTS(NP), .PTR_BITS(1), .TRANS_ID_BITS(IDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef DIV_SCHED_FLUSH_EN
    .flush_i(flush_i),
`endif
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_id_i(req_id_i),
    .div_valid_o(div_valid_o), .div_ready_i(div_ready_i), .div_op_o(div_op_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_id_o(div_id_o),
    .div_done_i(div_done_i), .div_result_i(div_result_i), .div_id_i(div_id_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_id_o(res_id_o), .id_err_o(id_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // round-robin rule: first requesting port counting up from the model pointer
  function automatic int model_grant(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++)
      if (v[(mptr + i) % NP]) return (mptr + i) % NP;
    return -1;
  endfunction

  function automatic logic [63:0] divide(input fu_op op, input logic [63:0] a, input logic [63:0] b);
    return (op inside {REM, REMU, REMW, REMUW}) ? a % b : a / b;
  endfunction

  task automatic randomize_ports;
    for (int p = 0; p < NP; p++) begin
      req_op_i[p] = fu_op'($urandom_range(0, 7));
      req_a_i[p] = {$urandom, $urandom};
      req_b_i[p] = {32'h0, $urandom} | 64'h1;
      req_id_i[p] = IDW'($urandom);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
    chk({tag, "_div_valid"}, 64'(div_valid_o), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid_o), 64'(0));
    chk({tag, "_id_err"}, 64'(id_err_o), 64'(0));
  endtask

  task automatic issue(input logic [NP-1:0] v, output int g);
    g = model_grant(v);
    req_valid_i = v;
    div_ready_i = 1'b1;
    res_ready_i = '0;
    div_done_i = 1'b0;
    #1;
    chk("grant", 64'(req_ready_o), 64'(NP'(1) << g));
    chk("div_valid", 64'(div_valid_o), 64'(1));
    chk("div_op", 64'(div_op_o), 64'(req_op_i[g]));
    chk("div_a", div_a_o, req_a_i[g]);
    chk("div_b", div_b_o, req_b_i[g]);
    chk("div_id", 64'(div_id_o), 64'(req_id_i[g]));
    mptr = (g + 1) % NP;
    tick;
  endtask

  // full transaction: grant, divider done after lat cycles, hold result for hold cycles, accept
  task automatic do_op(input logic [NP-1:0] v, input int lat, input int hold, input int ret);
    int g;
    logic [NP-1:0] own;
    logic [63:0] r;
    logic [IDW-1:0] rid;
    issue(v, g);
    own = NP'(1) << g;
    r = divide(req_op_i[g], req_a_i[g], req_b_i[g]);
    rid = (ret < 0) ? req_id_i[g] : IDW'(ret);
    res_ready_i = NP'($urandom);
    #1;
    chk("busy_req_ready", 64'(req_ready_o), 64'(0));
    chk("busy_div_valid", 64'(div_valid_o), 64'(0));
    for (int c = 1; c < lat; c++) begin
      tick;
      #1 chk("busy_res_valid", 64'(res_valid_o), 64'(0));
    end
    div_done_i = 1'b1;
    div_result_i = r;
    div_id_i = rid;
    tick;
    div_done_i = 1'b0;
    div_result_i = {$urandom, $urandom};
    div_id_i = IDW'($urandom);
    res_ready_i = NP'($urandom) & ~own;
    #1;
    chk("hold_res_valid", 64'(res_valid_o), 64'(own));
    chk("hold_res_data", res_data_o, r);
    chk("hold_res_id", 64'(res_id_o), 64'(rid));
    chk("hold_id_err", 64'(id_err_o), 64'(rid != req_id_i[g]));
    for (int h = 0; h < hold; h++) begin
      res_ready_i = NP'($urandom) & ~own;
      div_done_i = 1'($urandom);
      tick;
      #1;
      chk("stall_res_valid", 64'(res_valid_o), 64'(own));
      chk("stall_res_data", res_data_o, r);
      chk("stall_req_ready", 64'(req_ready_o), 64'(0));
      chk("stall_id_err", 64'(id_err_o), 64'(0));
    end
    res_ready_i = own | NP'($urandom);
    div_done_i = 1'b0;
    tick;
    res_ready_i = '0;
    #1;
    chk("idle_res_valid", 64'(res_valid_o), 64'(0));
    chk("idle_id_err", 64'(id_err_o), 64'(0));
  endtask

  initial begin
    int g;
    logic [NP-1:0] v;
    randomize_ports();
    @(negedge clk_i);
    req_valid_i = '1;
    div_ready_i = 1'b1;
    #1;
    chk_quiet("rst");
    chk("rst_res_data", res_data_o, 64'(0));
    chk("rst_res_id", 64'(res_id_o), 64'(0));
    req_valid_i = '0;
    tick;
    rst_ni = 1'b1;
    #1;
    // directed DIVU 100/7, id 3, done ten cycles after issue
    randomize_ports();
    req_op_i[0] = DIVU;
    req_a_i[0] = 64'd100;
    req_b_i[0] = 64'd7;
    req_id_i[0] = 3'd3;
    do_op(2'b01, 10, 0, -1);
    // both ports held valid: alternating grants
    for (int k = 0; k < 4; k++) begin
      randomize_ports();
      do_op(2'b11, int'($urandom_range(1, 4)), 0, -1);
    end
    randomize_ports();
    do_op(2'b11, 3, 20, -1);
    // id mismatch: stored 4, returned 5
    randomize_ports();
    req_id_i[0] = 3'd4;
    do_op(2'b01, 4, 0, 5);
    // no grant without div_ready; stray done in IDLE ignored
    req_valid_i = 2'b11;
    div_ready_i = 1'b0;
    div_done_i = 1'b1;
    #1 chk_quiet("not_ready");
    tick;
    div_done_i = 1'b0;
    #1 chk_quiet("stray_done");
    // reset while BUSY, then a late done
    randomize_ports();
    issue(2'b01, g);
    rst_ni = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst_res_data", res_data_o, 64'(0));
    chk("midrst_res_id", 64'(res_id_o), 64'(0));
    mptr = 0;
    req_valid_i = '0;
    tick;
    rst_ni = 1'b1;
    div_done_i = 1'b1;
    div_result_i = {$urandom, $urandom};
    tick;
    div_done_i = 1'b0;
    #1 chk_quiet("late_done");
    randomize_ports();
    do_op(2'b11, 2, 1, -1);
`ifdef DIV_SCHED_FLUSH_EN
    randomize_ports();
    issue(2'b01, g);
    flush_i = 1'b1;
    req_valid_i = '0;
    tick;
    flush_i = 1'b0;
    tick;
    div_done_i = 1'b1;
    tick;
    div_done_i = 1'b0;
    #1 chk_quiet("flush_busy");
    req_valid_i = 2'b10;
    flush_i = 1'b1;
    #1 chk("flush_idle_grant", 64'(req_ready_o), 64'(0));
    tick;
    flush_i = 1'b0;
`endif
    for (int k = 0; k < 40; k++) begin
      randomize_ports();
      v = NP'($urandom_range(1, (1 << NP) - 1));
      g = model_grant(v);
      if ($urandom_range(0, 3) == 0) begin
        req_valid_i = '0;
        div_ready_i = 1'b1;
        #1 chk_quiet("gap");
        tick;
      end
      do_op(v, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? int'(req_id_i[g] ^ 3'd1) : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
